// File: rtl/adder_pipe_scheduler.sv
// Round-robin front end that shares one fully pipelined adder among NREQ requesters.
// Optional ADDER_SCHED_STATS_EN adds saturating accept/stall counters.
module adder_pipe_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int LAT   = 8,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [WIDTH-1:0]      adder_a,
  output logic [WIDTH-1:0]      adder_b,
  output logic                  adder_c,
  output logic                  adder_en,
  input  logic [WIDTH-1:0]      adder_s,
  input  logic                  adder_carry
`ifdef ADDER_SCHED_STATS_EN
  ,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_stalls
`endif
);

  logic [ID_W-1:0] r_ptr;
  logic [LAT-1:0]  r_tag_valid;
  logic [ID_W-1:0] r_tag_id [LAT];

  logic            w_stall;
  logic            w_found;
  logic            w_accept;
  logic [ID_W-1:0] w_grant;
  logic [ID_W-1:0] w_ptr_next;

  assign w_stall  = rsp_valid & ~rsp_ready;
  assign adder_en = ~w_stall;

  // Search ptr, ptr+1, ... ; iterating downward lets the closest candidate win.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    v_idx   = '0;
    w_grant = '0;
    w_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      v_idx = ID_W'((int'(r_ptr) + i) % NREQ);
      if (req_valid[v_idx]) begin
        w_grant = v_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_accept   = w_found & ~w_stall & ~rst;
  assign w_ptr_next = (w_grant == ID_W'(NREQ - 1)) ? '0 : w_grant + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_grant] = 1'b1;
  end

  assign adder_a = w_found ? req_a[int'(w_grant)*WIDTH +: WIDTH] : '0;
  assign adder_b = w_found ? req_b[int'(w_grant)*WIDTH +: WIDTH] : '0;
  assign adder_c = w_found ? req_cin[w_grant] : 1'b0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      r_ptr       <= '0;
      r_tag_valid <= '0;
    end else if (adder_en) begin
      if (w_accept) r_ptr <= w_ptr_next;
      r_tag_valid <= {r_tag_valid[LAT-2:0], w_accept};
    end
  end

  // NOTE: tag ids are not reset; an id is only observed when its valid bit is set.
  always_ff @(posedge clk) begin
    if (adder_en) begin
      r_tag_id[0] <= w_grant;
      for (int i = 1; i < LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  assign rsp_valid = r_tag_valid[LAT-1];
  assign rsp_id    = r_tag_id[LAT-1];
  assign rsp_sum   = adder_s;
  assign rsp_cout  = adder_carry;

`ifdef ADDER_SCHED_STATS_EN
  logic [15:0] r_stat_ops;
  logic [15:0] r_stat_stalls;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_ops    <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_accept && (r_stat_ops != 16'hFFFF))   r_stat_ops    <= r_stat_ops + 16'd1;
      if (w_stall && (r_stat_stalls != 16'hFFFF)) r_stat_stalls <= r_stat_stalls + 16'd1;
    end
  end

  assign stat_ops    = r_stat_ops;
  assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_adder_pipe_scheduler.sv
// Directed bench for adder_pipe_scheduler with a behavioural pipelined adder and a result scoreboard.
// Stats counters are checked when ADDER_SCHED_STATS_EN is defined.
module tb_adder_pipe_scheduler;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int LAT   = 8;
  localparam int ID_W  = $clog2(NREQ);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [WIDTH:0]  val;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [WIDTH-1:0]      adder_a;
  logic [WIDTH-1:0]      adder_b;
  logic                  adder_c;
  logic                  adder_en;
  logic [WIDTH-1:0]      adder_s;
  logic                  adder_carry;
`ifdef ADDER_SCHED_STATS_EN
  logic [15:0]           stat_ops;
  logic [15:0]           stat_stalls;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  adder_pipe_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_c    (adder_c),
    .adder_en   (adder_en),
    .adder_s    (adder_s),
    .adder_carry(adder_carry)
`ifdef ADDER_SCHED_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural fully pipelined adder: LAT enabled stages, never reset.
  logic [WIDTH:0] m_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) m_pipe[i] = '0;
  always @(posedge clk) begin
    if (adder_en) begin
      m_pipe[0] <= (WIDTH+1)'(adder_a) + (WIDTH+1)'(adder_b) + (WIDTH+1)'(adder_c);
      for (int i = 1; i < LAT; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end
  assign adder_s     = m_pipe[LAT-1][WIDTH-1:0];
  assign adder_carry = m_pipe[LAT-1][WIDTH];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin);
    req_a[k*WIDTH +: WIDTH] = a;
    req_b[k*WIDTH +: WIDTH] = b;
    req_cin[k]              = cin;
  endtask

  // Monitor: handshake legality, scoreboard push on accept, pop and compare on retire.
  always @(negedge clk) begin
    exp_t e;
    check("rdy_onehot", 32'($onehot0(req_ready)), 1);
    check("rdy_wo_valid", 32'(req_ready & ~req_valid), 0);
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        e.id  = ID_W'(k);
        e.val = (WIDTH+1)'(req_a[k*WIDTH +: WIDTH]) + (WIDTH+1)'(req_b[k*WIDTH +: WIDTH])
              + (WIDTH+1)'(req_cin[k]);
        q.push_back(e);
      end
    end
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_val", 32'({rsp_cout, rsp_sum}), 32'(e.val));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;

    // Reset state.
    tick();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_adder_en", 32'(adder_en), 1);
    tick();
    rst = 1'b0;

    // Single op from req0, exact latency of LAT cycles.
    set_ops(0, 8'd3, 8'd5, 1'b1);
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_grant", 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = '0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      check("single_latency", 32'(rsp_valid), 32'(c == LAT));
      if (c == LAT) begin
        check("single_sum", 32'(rsp_sum), 9);
        check("single_cout", 32'(rsp_cout), 0);
        check("single_id", 32'(rsp_id), 0);
      end
      tick();
    end

    // ptr is now 1: req2 beats req0, then req0 follows. req2 overflows.
    set_ops(2, 8'd200, 8'd100, 1'b1);
    set_ops(0, 8'd17, 8'd34, 1'b0);
    req_valid = 4'b0101;
    @(negedge clk);
    check("ptr1_grant", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    check("ptr3_grant", 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = '0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rsp_id === 2'd2) begin
        check("ovf_sum", 32'(rsp_sum), 45);
        check("ovf_cout", 32'(rsp_cout), 1);
      end
      tick();
    end
    check("drain_ovf", q.size(), 0);

    // All requesters held: back-to-back round robin, back-to-back responses.
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      if (i < 12) begin
        req_valid = '1;
        for (int k = 0; k < NREQ; k++)
          set_ops(k, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (i < 12) check("rr_grant", 32'(req_ready), 32'(4'b0001 << (i % 4)));
      check("b2b_valid", 32'(rsp_valid), 32'(i >= LAT && i < 12 + LAT));
      tick();
    end
    check("drain_rr", q.size(), 0);

    // Backpressure for 3 cycles on the first response with requests pending.
    set_ops(0, 8'd255, 8'd255, 1'b1);
    set_ops(1, 8'd0, 8'd0, 1'b0);
    set_ops(2, 8'd128, 8'd128, 1'b0);
    set_ops(3, 8'd1, 8'd254, 1'b1);
    for (int i = 0; i <= 21; i++) begin
      req_valid = (i <= 11) ? '1 : '0;
      rsp_ready = !(i >= 8 && i <= 10);
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'(i >= 8 && i <= 19));
      if (i >= 8 && i <= 10) begin
        check("bp_adder_en", 32'(adder_en), 0);
        check("bp_ready", 32'(req_ready), 0);
        check("bp_queue", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          check("bp_hold_id", 32'(rsp_id), 32'(q[0].id));
          check("bp_hold_val", 32'({rsp_cout, rsp_sum}), 32'(q[0].val));
        end
      end
      if (i == 11) check("bp_grant_kept", 32'(req_ready), 32'(4'b0001));
      tick();
    end
    rsp_ready = 1'b1;
    check("drain_bp", q.size(), 0);

    // Reset with 5 ops in flight: none may come back, ptr returns to 0.
    for (int i = 0; i < 5; i++) begin
      req_valid = '1;
      tick();
    end
    req_valid = '1;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("rst_mid_ready", 32'(req_ready), 0);
    check("rst_mid_en", 32'(adder_en), 1);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      check("rst_flush", 32'(rsp_valid), 0);
      tick();
    end
    set_ops(1, 8'd10, 8'd20, 1'b1);
    set_ops(3, 8'd40, 8'd50, 1'b0);
    req_valid = 4'b1010;
    @(negedge clk);
    check("rst_ptr_grant", 32'(req_ready), 32'(4'b0010));
    tick();
    req_valid = '0;
    for (int c = 0; c < LAT + 2; c++) tick();
    check("drain_rst", q.size(), 0);

    // 10 accepts and 4 stall cycles for the statistics counters.
    do_reset();
    for (int i = 0; i <= 25; i++) begin
      req_valid = (i < 8 || (i >= 12 && i < 14)) ? '1 : '0;
      rsp_ready = !(i >= 8 && i <= 11);
      @(negedge clk);
      if (i >= 8 && i <= 11) check("st_stall", 32'(adder_en), 0);
      tick();
    end
    rsp_ready = 1'b1;
    check("drain_stats", q.size(), 0);
`ifdef ADDER_SCHED_STATS_EN
    check("stat_ops", 32'(stat_ops), 10);
    check("stat_stalls", 32'(stat_stalls), 4);
    do_reset();
    @(negedge clk);
    check("stat_ops_rst", 32'(stat_ops), 0);
    check("stat_stalls_rst", 32'(stat_stalls), 0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
